// File: rtl/perf_snapshot_rdout.sv
// Per-strobe saturating event counters with lossless window snapshot,
// streamed out as one header word followed by NUM_CNT count words over valid/ready.
module perf_snapshot_rdout #(
    parameter int NUM_CNT   = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_CNT-1:0]   inc,
    input  logic                 snap,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [CNT_WIDTH-1:0] out_dat,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    localparam int                   IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0]   shadow_q, shadow_d;
    logic [NUM_CNT-1:0]                  sat_q, sat_d;
    logic [NUM_CNT-1:0]                  shadow_sat_q, shadow_sat_d;
    logic [7:0]                          seq_q, seq_d;
    logic [7:0]                          miss_q, miss_d;
    logic [7:0]                          hdr_seq_q, hdr_seq_d;
    logic [7:0]                          hdr_miss_q, hdr_miss_d;
    logic                                last_hs;
    logic                                snap_accept;
    logic [CNT_WIDTH-1:0]                hdr_word;

    // A snap coinciding with the final-word handshake starts the next window with no bubble.
    assign last_hs     = (state_q == DATA) && (idx_q == LAST_IDX) && out_rdy;
    assign snap_accept = snap && ((state_q == IDLE) || last_hs);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (snap) state_d = HDR;
            end
            HDR: begin
                if (out_rdy) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (out_rdy) begin
                    if (idx_q == LAST_IDX) state_d = snap ? HDR : IDLE;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // On capture the live counter restarts at this cycle's event, so nothing is lost or counted twice.
    always_comb begin
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        shadow_d     = shadow_q;
        shadow_sat_d = shadow_sat_q;
        if (snap_accept) begin
            shadow_sat_d = sat_q;
        end
        for (int k = 0; k < NUM_CNT; k++) begin
            if (snap_accept) begin
                shadow_d[k] = cnt_q[k];
                cnt_d[k]    = (enable && inc[k]) ? CNT_WIDTH'(1) : '0;
                sat_d[k]    = 1'b0;
            end else if (enable && inc[k]) begin
                if (cnt_q[k] == CNT_MAX) sat_d[k] = 1'b1;
                else                     cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        seq_d      = seq_q;
        miss_d     = miss_q;
        hdr_seq_d  = hdr_seq_q;
        hdr_miss_d = hdr_miss_q;
        if (snap_accept) begin
            hdr_seq_d  = seq_q;
            hdr_miss_d = miss_q;
            seq_d      = seq_q + 8'd1;
            miss_d     = 8'd0;
        end else if (snap && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    // Sat flags are written last so they win if NUM_CNT spills over the lower header fields.
    always_comb begin
        hdr_word                = '0;
        hdr_word[31:24]         = hdr_seq_q;
        hdr_word[15:8]          = hdr_miss_q;
        hdr_word[NUM_CNT-1:0]   = shadow_sat_q;
        out_val  = (state_q != IDLE);
        busy     = (state_q != IDLE);
        out_dat  = '0;
        out_last = 1'b0;
        case (state_q)
            HDR:  out_dat = hdr_word;
            DATA: begin
                out_dat  = shadow_q[idx_q];
                out_last = (idx_q == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            sat_q        <= '0;
            shadow_sat_q <= '0;
            seq_q        <= '0;
            miss_q       <= '0;
            hdr_seq_q    <= '0;
            hdr_miss_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            sat_q        <= sat_d;
            shadow_sat_q <= shadow_sat_d;
            seq_q        <= seq_d;
            miss_q       <= miss_d;
            hdr_seq_q    <= hdr_seq_d;
            hdr_miss_q   <= hdr_miss_d;
        end
    end

endmodule
